// File: rtl/finalsoc_key_input_pio.sv
// Avalon-MM input PIO: 3-flop pin synchronizer, sticky edge capture, masked level irq; readdata registered (one wait state).
// Define KEY_PIO_BIT_CLEAR_EN to clear only the EDGE_CAPTURE bits written as 1; otherwise any write to address 3 clears all.
module finalsoc_key_input_pio #(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;
  localparam logic [1:0] FILL_FULL  = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [1:0]       fill_q, fill_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             primed;
  logic             wr_en;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] cap_clr;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  assign primed = (fill_q == FILL_FULL);
  assign wr_en  = chipselect & ~write_n;

  always_comb begin
    edge_raw = '0;
    if (EDGE_TYPE == 0) begin
      edge_raw = sync2_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_raw = ~sync2_q & prev_q;
    end else begin
      edge_raw = sync2_q ^ prev_q;
    end
  end

  // Until the pipeline holds three post-reset samples, prev_q still carries reset zeros.
  assign edge_det = primed ? edge_raw : '0;
  assign fill_d   = primed ? fill_q : fill_q + 2'd1;

`ifdef KEY_PIO_BIT_CLEAR_EN
  assign clr_bits = writedata[WIDTH-1:0];
`else
  assign clr_bits = '1;
`endif

  always_comb begin
    mask_d  = mask_q;
    cap_clr = '0;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE)) begin
      cap_clr = clr_bits;
    end
    // Set after clear so a coincident edge is never lost.
    cap_d = (cap_q & ~cap_clr) | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = sync2_q;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = cap_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      fill_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      fill_q     <= fill_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_finalsoc_key_input_pio.sv
// Bench for finalsoc_key_input_pio: directed scenarios plus randomized traffic against a pin-history reference model.
module tb_finalsoc_key_input_pio;
  localparam int W  = 4;
  localparam int ET = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   readdata;
  logic          irq;

  int total = 0;
  int bad = 0;

  // Reference model: pin value sampled at every post-reset edge (index 0 holds the reset-time zero level).
  logic [W-1:0]  hist[$];
  logic [W-1:0]  m_mask;
  logic [W-1:0]  m_cap;
  logic [31:0]   m_rd;

  finalsoc_key_input_pio #(.WIDTH(W), .EDGE_TYPE(ET)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist = {};
    hist.push_back('0);
    m_mask = '0;
    m_cap  = '0;
    m_rd   = '0;
  endtask

  function automatic logic m_irq();
    return |(m_cap & m_mask);
  endfunction

  // Advance one clock; model sees the inputs as they stood at the edge. Returns #1 after the edge.
  task automatic tick();
    logic [W-1:0] s_in, newlvl, oldlvl, det, clr;
    logic         s_cs, s_wn;
    logic [1:0]   s_addr;
    logic [31:0]  s_wd;
    int           e;
    s_in = in_port; s_cs = chipselect; s_wn = write_n; s_addr = address; s_wd = writedata;
    @(posedge clk);
    if (reset_n) begin
      hist.push_back(s_in);
      e = hist.size() - 1;
      det = '0;
      if (e >= 4) begin
        newlvl = hist[e-2];
        oldlvl = hist[e-3];
        case (ET)
          0:       det = newlvl & ~oldlvl;
          1:       det = ~newlvl & oldlvl;
          default: det = newlvl ^ oldlvl;
        endcase
      end
      m_rd = '0;
      case (s_addr)
        2'd0:    if (e >= 2) m_rd[W-1:0] = hist[e-2];
        2'd2:    m_rd[W-1:0] = m_mask;
        2'd3:    m_rd[W-1:0] = m_cap;
        default: m_rd = '0;
      endcase
      clr = '0;
      if (s_cs && !s_wn && s_addr == 2'd2) m_mask = s_wd[W-1:0];
`ifdef KEY_PIO_BIT_CLEAR_EN
      if (s_cs && !s_wn && s_addr == 2'd3) clr = s_wd[W-1:0];
`else
      if (s_cs && !s_wn && s_addr == 2'd3) clr = '1;
`endif
      m_cap = (m_cap & ~clr) | det;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic do_reset(input logic [W-1:0] pins);
    in_port = pins;
    reset_n = 1'b0;
    model_reset();
    ticks(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    in_port = 4'hF;
    reset_n = 1'b0;
    model_reset();
    ticks(3);
    total++;
    if (irq !== 1'b0 || readdata !== 32'h0) begin
      bad++; $display("FAIL reset_hold: irq=%b readdata=%h required irq=0 readdata=0", irq, readdata);
    end
    reset_n = 1'b1;
    address = 2'd0;
    ticks(5);
    total++;
    if (readdata !== 32'h0000000F) begin
      bad++; $display("FAIL reset_data: readdata=%h required 0000000f", readdata);
    end
    address = 2'd3;
    tick();
    total++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL reset_priming: edge=%h irq=%b required 0 and 0", readdata, irq);
    end
  endtask

  task automatic test_falling_capture();
    bus_write(2'd2, 32'h1);
    in_port = 4'hE;
    ticks(2);
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL capture_early: irq=%b required 0 one clock before capture", irq);
    end
    tick();
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL capture_irq: irq=%b required 1", irq);
    end
    address = 2'd3;
    tick();
    total++;
    if (readdata !== 32'h1) begin
      bad++; $display("FAIL capture_read: readdata=%h required 00000001", readdata);
    end
  endtask

  task automatic test_bit_clear();
    logic [31:0] exp;
    do_reset(4'hF);
    ticks(4);
    in_port = 4'hA;
    ticks(3);
    address = 2'd3;
    tick();
    total++;
    if (readdata !== 32'h5) begin
      bad++; $display("FAIL clear_setup: readdata=%h required 00000005", readdata);
    end
    bus_write(2'd3, 32'h4);
    address = 2'd3;
    tick();
`ifdef KEY_PIO_BIT_CLEAR_EN
    exp = 32'h1;
`else
    exp = 32'h0;
`endif
    total++;
    if (readdata !== exp) begin
      bad++; $display("FAIL clear_write: readdata=%h required %h", readdata, exp);
    end
  endtask

  task automatic test_clear_collision();
    in_port = 4'hE;
    ticks(3);
    in_port = 4'hA;
    ticks(2);
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    tick();
    total++;
    if (readdata !== 32'h4) begin
      bad++; $display("FAIL clear_collision: readdata=%h required 00000004", readdata);
    end
  endtask

  task automatic test_irq_mask();
    do_reset(4'hF);
    ticks(4);
    in_port = 4'hD;
    ticks(3);
    bus_write(2'd2, 32'h1);
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL mask_off: irq=%b required 0", irq);
    end
    bus_write(2'd2, 32'h2);
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL mask_on: irq=%b required 1", irq);
    end
    bus_write(2'd2, 32'h0);
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL mask_zero: irq=%b required 0", irq);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp [4];
    bus_write(2'd2, 32'h2);
    address = 2'd2;
    tick();
    total++;
    if (irq !== 1'b1 || readdata !== 32'h2) begin
      bad++; $display("FAIL arst_setup: irq=%b readdata=%h required 1 and 00000002", irq, readdata);
    end
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (irq !== 1'b0 || readdata !== 32'h0) begin
      bad++; $display("FAIL arst_async: irq=%b readdata=%h required 0 and 0", irq, readdata);
    end
    #2 reset_n = 1'b1;
    in_port = 4'hF;
    ticks(4);
    for (int a = 0; a < 2; a++) bus_write(2'(a), $urandom());
    exp[0] = 32'hF; exp[1] = 32'h0; exp[2] = 32'h0; exp[3] = 32'h0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      total++;
      if (readdata !== exp[a] || readdata !== m_rd) begin
        bad++; $display("FAIL arst_regs[%0d]: readdata=%h required %h", a, readdata, exp[a]);
      end
    end
  endtask

  task automatic test_random();
    do_reset(W'($urandom()));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) in_port = W'($urandom());
      chipselect = 1'($urandom());
      write_n    = ($urandom_range(3) != 0);
      address    = 2'($urandom());
      writedata  = $urandom();
      tick();
      total++;
      if (readdata !== m_rd || irq !== m_irq()) begin
        bad++; $display("FAIL random[%0d]: readdata=%h irq=%b required %h %b", i, readdata, irq, m_rd, m_irq());
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_falling_capture();
    test_bit_clear();
    test_clear_collision();
    test_irq_mask();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
